// File: rtl/spi.sv
// Loopback SPI: one mode-0, MSB-first master wired to one slave through internal SCLK/MOSI/CS_N.
// Optional macro SPI_CONTINUOUS_EN: IDLE always starts a transfer (back-to-back) instead of only on a data change.
module spi #(
  parameter int unsigned HALF_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] master_data_in,
  output logic [7:0] slave_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned        DIV_W    = 3;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(HALF_DIV - 1);

  state_e           state_q, state_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       last_sent_q, last_sent_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       slave_data_q, slave_data_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  logic start_s;
  logic tick_s;
  logic sclk_rise_s;

`ifdef SPI_CONTINUOUS_EN
  assign start_s = 1'b1;
`else
  assign start_s = (master_data_in != last_sent_q);
`endif

  assign tick_s      = (state_q == XFER) && (div_cnt_q == DIV_LAST);
  assign sclk_rise_s = tick_s && !sclk_q;

  // Master FSM: trigger, SCLK divider, MOSI shifting and chip select.
  always_comb begin
    state_d     = state_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    tx_shift_d  = tx_shift_q;
    last_sent_d = last_sent_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    case (state_q)
      IDLE: begin
        sclk_d    = 1'b0;
        div_cnt_d = {DIV_W{1'b0}};
        if (start_s) begin
          tx_shift_d  = master_data_in;
          last_sent_d = master_data_in;
          cs_n_d      = 1'b0;
          mosi_d      = master_data_in[7];
          bit_cnt_d   = 4'd0;
          state_d     = XFER;
        end else begin
          cs_n_d  = 1'b1;
          state_d = IDLE;
        end
      end
      XFER: begin
        // MOSI always mirrors the MSB of the shifter; only the falling edge advances it.
        mosi_d = tx_shift_q[7];
        if (tick_s) begin
          div_cnt_d = {DIV_W{1'b0}};
          sclk_d    = ~sclk_q;
          if (sclk_q) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            mosi_d     = tx_shift_q[6];
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_d = DONE;
            end else begin
              state_d = XFER;
            end
          end else begin
            state_d = XFER;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      DONE: begin
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Slave: sample MOSI on SCLK rise, publish the whole byte only when the master reaches DONE.
  always_comb begin
    rx_shift_d   = rx_shift_q;
    slave_data_d = slave_data_q;
    if (sclk_rise_s && !cs_n_q) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_q};
    end else begin
      rx_shift_d = rx_shift_q;
    end
    if (state_q == DONE) begin
      slave_data_d = rx_shift_q;
    end else begin
      slave_data_d = slave_data_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      tx_shift_q   <= 8'h00;
      last_sent_q  <= 8'h00;
      rx_shift_q   <= 8'h00;
      slave_data_q <= 8'h00;
      bit_cnt_q    <= 4'd0;
      div_cnt_q    <= {DIV_W{1'b0}};
    end else begin
      state_q      <= state_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      tx_shift_q   <= tx_shift_d;
      last_sent_q  <= last_sent_d;
      rx_shift_q   <= rx_shift_d;
      slave_data_q <= slave_data_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
    end
  end

  assign slave_data = slave_data_q;

endmodule

// File: tb/tb_spi.sv
// Directed bench for spi (HALF_DIV=1): scoreboard of expected slave bytes popped at each CS_N release,
// plus per-transfer checks of SCLK shape, MOSI order and latency.
module tb_spi;

  logic       clk;
  logic       rst;
  logic [7:0] master_data_in;
  logic [7:0] slave_data;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];

  spi #(.HALF_DIV(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .master_data_in (master_data_in),
    .slave_data     (slave_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: each CS_N release outside reset must deliver the oldest expected byte.
  initial begin
    logic       prev_cs;
    logic [7:0] exp_b;
    prev_cs = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (prev_cs === 1'b0 && dut.cs_n_q === 1'b1 && rst === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_unexpected observed=%h expected=none", slave_data);
        end else begin
          exp_b = sb.pop_front();
          chk("sb_slave_data", slave_data, exp_b);
        end
      end
      prev_cs = dut.cs_n_q;
    end
  end

  // Follows one transfer from its start edge through the slave_data update 17 edges later.
  task automatic observe_xfer(input logic [7:0] exp_byte, input logic [7:0] prev_sd,
                              input int chg_k, input logic [7:0] chg_val);
    logic [7:0] mseq;
    int         rises;
    logic       pat_ok;
    logic       hold_ok;
    mseq    = 8'h00;
    rises   = 0;
    pat_ok  = 1'b1;
    hold_ok = 1'b1;
    @(posedge clk); #1;
    chk("start_cs_low", {7'd0, dut.cs_n_q}, 8'd0);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (dut.sclk_q !== k[0]) pat_ok = 1'b0;
      if (dut.sclk_q === 1'b1) begin
        mseq  = {mseq[6:0], dut.mosi_q};
        rises = rises + 1;
      end
      if (dut.cs_n_q !== 1'b0 || slave_data !== prev_sd) hold_ok = 1'b0;
      if (k == chg_k) master_data_in = chg_val;
    end
    @(posedge clk); #1;
    chk("latency_slave_data", slave_data, exp_byte);
    chk("end_cs_high", {7'd0, dut.cs_n_q}, 8'd1);
    chk("sclk_pattern", {7'd0, pat_ok}, 8'd1);
    chk("sclk_rises", 8'(rises), 8'd8);
    chk("mosi_sequence", mseq, exp_byte);
    chk("no_partial_update", {7'd0, hold_ok}, 8'd1);
  endtask

  initial begin
    rst            = 1'b1;
    master_data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_slave_data", slave_data, 8'h00);
    chk("rst_cs_n", {7'd0, dut.cs_n_q}, 8'd1);
    chk("rst_sclk", {7'd0, dut.sclk_q}, 8'd0);

`ifdef SPI_CONTINUOUS_EN
    begin
      int   falls[3];
      int   nf;
      logic prev;
      nf   = 0;
      prev = 1'b1;
      @(negedge clk);
      master_data_in = 8'h5A;
      repeat (3) sb.push_back(8'h5A);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 54; k++) begin
        @(posedge clk); #1;
        if (prev === 1'b1 && dut.cs_n_q === 1'b0 && nf < 3) begin
          falls[nf] = k;
          nf = nf + 1;
        end
        prev = dut.cs_n_q;
      end
      chk("cont_fall_count", 8'(nf), 8'd3);
      chk("cont_period_a", 8'(falls[1] - falls[0]), 8'd18);
      chk("cont_period_b", 8'(falls[2] - falls[1]), 8'd18);
      chk("cont_slave_data", slave_data, 8'h5A);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
    end
`else
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("zero_no_start", {7'd0, dut.cs_n_q}, 8'd1);
    end
    chk("zero_slave_data", slave_data, 8'h00);

    @(negedge clk);
    master_data_in = 8'hAA;
    sb.push_back(8'hAA);
    observe_xfer(8'hAA, 8'h00, 0, 8'hAA);

    @(negedge clk);
    master_data_in = 8'h3C;
    sb.push_back(8'h3C);
    observe_xfer(8'h3C, 8'hAA, 0, 8'h3C);
    begin
      logic idle_ok;
      idle_ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (dut.cs_n_q !== 1'b1 || dut.sclk_q !== 1'b0) idle_ok = 1'b0;
      end
      chk("hold_no_retrigger", {7'd0, idle_ok}, 8'd1);
    end

    @(negedge clk);
    master_data_in = 8'h81;
    sb.push_back(8'h81);
    sb.push_back(8'hFF);
    observe_xfer(8'h81, 8'h3C, 6, 8'hFF);
    observe_xfer(8'hFF, 8'h81, 0, 8'hFF);

    @(negedge clk);
    master_data_in = 8'h55;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("abort_slave_data", slave_data, 8'h00);
    chk("abort_cs_n", {7'd0, dut.cs_n_q}, 8'd1);
    chk("abort_sclk", {7'd0, dut.sclk_q}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(8'h55);
    observe_xfer(8'h55, 8'h00, 0, 8'h55);
`endif

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
